// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, state and result-flag types for the sequential divider
package div_pkg;

    localparam int DEFAULT_WIDTH = 16;

`ifdef SEQ_DIVIDER16_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, FIXUP} state_e;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
`endif

    typedef struct packed {
        logic div_by_zero;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         qbit_o
);

    // W+1 bits so the bit shifted out of the partial remainder takes part in the compare
    logic [W:0] trial;

    assign trial  = {rem_i, bit_i};
    assign qbit_o = (trial >= {1'b0, divisor_i});
    // rem_i < divisor_i keeps the difference inside W bits
    assign rem_o  = qbit_o ? (trial[W-1:0] - divisor_i) : trial[W-1:0];

endmodule

// File: rtl/seq_divider16.sv
// rtl/seq_divider16.sv - radix-2 restoring divider, 2W/W -> W quotient and remainder
// Optional two's-complement operands under SEQ_DIVIDER16_SIGNED_EN (adds one fixup cycle).
module seq_divider16
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    flags_t             flags_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [2*WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0]   dv_mag;
    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic [WIDTH-1:0]   next_shift;

`ifdef SEQ_DIVIDER16_SIGNED_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic neg_q;
    logic dd_neg_q;
    assign dd_mag = dividend[2*WIDTH-1] ? -dividend : dividend;
    assign dv_mag = divisor[WIDTH-1] ? -divisor : divisor;
`else
    assign dd_mag = dividend;
    assign dv_mag = divisor;
`endif

    div_step #(.W(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (shift_q[WIDTH-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // dividend bits leave at the top while quotient bits enter at the bottom
    assign next_shift = {shift_q[WIDTH-2:0], step_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            shift_q     <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SEQ_DIVIDER16_SIGNED_EN
            neg_q       <= 1'b0;
            dd_neg_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        divisor_q  <= dv_mag;
                        cnt_q      <= '0;
`ifdef SEQ_DIVIDER16_SIGNED_EN
                        neg_q      <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
                        dd_neg_q   <= dividend[2*WIDTH-1];
`endif
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            flags_q     <= '{div_by_zero: 1'b1, overflow: 1'b0};
                            quotient_q  <= '1;
                            remainder_q <= dividend[WIDTH-1:0];
                        end else if (dd_mag[2*WIDTH-1:WIDTH] >= dv_mag) begin
                            state_q     <= DONE;
                            flags_q     <= '{div_by_zero: 1'b0, overflow: 1'b1};
                            quotient_q  <= '1;
                            remainder_q <= '0;
                        end else begin
                            state_q <= RUN;
                            rem_q   <= dd_mag[2*WIDTH-1:WIDTH];
                            shift_q <= dd_mag[WIDTH-1:0];
                        end
                    end
                end
                RUN: begin
                    rem_q   <= step_rem;
                    shift_q <= next_shift;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        quotient_q  <= next_shift;
                        remainder_q <= step_rem;
`ifdef SEQ_DIVIDER16_SIGNED_EN
                        state_q     <= FIXUP;
`else
                        state_q     <= DONE;
`endif
                    end
                end
`ifdef SEQ_DIVIDER16_SIGNED_EN
                FIXUP: begin
                    state_q <= DONE;
                    if (neg_q ? (quotient_q > HALF) : (quotient_q > HALF - 1'b1)) begin
                        flags_q     <= '{div_by_zero: 1'b0, overflow: 1'b1};
                        quotient_q  <= '1;
                        remainder_q <= '0;
                    end else begin
                        quotient_q  <= neg_q ? -quotient_q : quotient_q;
                        remainder_q <= dd_neg_q ? -remainder_q : remainder_q;
                    end
                end
`endif
                DONE: begin
                    // out_valid trails the DONE entry by one edge; results are already stable
                    if (out_valid_q && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        flags_q     <= '0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = flags_q.div_by_zero;
    assign overflow    = flags_q.overflow;

endmodule

// File: tb/tb_seq_divider16.sv
// tb/tb_seq_divider16.sv - randomized self-checking bench for seq_divider16 (unsigned build)
module tb_seq_divider16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    seq_divider16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: true integer division, with the error conventions for zero divisor and wide quotient
    function automatic void model(input logic [31:0] dd, input logic [15:0] dv,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic z, output logic o, output int lat);
        logic [31:0] qq;
        z = 1'b0; o = 1'b0;
        if (dv == 16'h0) begin
            z = 1'b1; q = 16'hFFFF; r = dd[15:0]; lat = 1;
        end else begin
            qq = dd / {16'h0, dv};
            if (qq > 32'h0000FFFF) begin
                o = 1'b1; q = 16'hFFFF; r = 16'h0; lat = 1;
            end else begin
                q = qq[15:0];
                qq = dd % {16'h0, dv};
                r = qq[15:0];
                lat = 17;
            end
        end
    endfunction

    // Drives one accept and waits (bounded) for out_valid; returns what was observed
    task automatic do_div(input logic [31:0] dd, input logic [15:0] dv,
                          output logic rdy, output int lat,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic z, output logic o);
        @(negedge clk);
        dividend = dd; divisor = dv; in_valid = 1'b1;
        rdy = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient; r = remainder; z = div_by_zero; o = overflow;
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({quotient, remainder} !== 32'h0) begin errors++; $display("FAIL reset_results: got %h/%h expected 0/0", quotient, remainder); end
        checks++; if ({div_by_zero, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {div_by_zero, overflow}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] dds [4] = '{32'h0000C350, 32'hFFFE0001, 32'h00010000, 32'h00001234};
        logic [15:0] dvs [4] = '{16'h00C8, 16'hFFFF, 16'h0001, 16'h0000};
        logic [15:0] eq, er, q, r;
        logic ez, eo, z, o, rdy;
        int elat, lat;
        for (int i = 0; i < 4; i++) begin
            model(dds[i], dvs[i], eq, er, ez, eo, elat);
            do_div(dds[i], dvs[i], rdy, lat, q, r, z, o);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL directed%0d_ready: got %b expected 1", i, rdy); end
            checks++; if (lat != elat) begin errors++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, elat); end
            checks++; if ({q, r} !== {eq, er}) begin errors++; $display("FAIL directed%0d_result: got %h/%h expected %h/%h", i, q, r, eq, er); end
            checks++; if ({z, o} !== {ez, eo}) begin errors++; $display("FAIL directed%0d_flags: got %b expected %b", i, {z, o}, {ez, eo}); end
            retire();
            checks++; if ({out_valid, in_ready, div_by_zero, overflow} !== 4'b0100) begin
                errors++; $display("FAIL directed%0d_idle: got %b expected 0100", i, {out_valid, in_ready, div_by_zero, overflow});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] q, r;
        logic z, o, rdy;
        int lat;
        do_div(32'h00000065, 16'h0007, rdy, lat, q, r, z, o);
        checks++; if (lat != 17) begin errors++; $display("FAIL hold_latency: got %0d expected 17", lat); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            dividend = $urandom; divisor = 16'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL hold%0d_handshake: got %b expected 10", c, {out_valid, in_ready}); end
            checks++; if ({quotient, remainder, div_by_zero, overflow} !== {16'h000E, 16'h0003, 2'b00}) begin
                errors++; $display("FAIL hold%0d_result: got %h/%h flags %b expected 000e/0003 flags 00", c, quotient, remainder, {div_by_zero, overflow});
            end
        end
        retire();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL hold_release: got %b expected 01", {out_valid, in_ready}); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] q, r;
        logic z, o, rdy;
        int lat;
        @(negedge clk);
        dividend = 32'h12345678; divisor = 16'h9999; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid, div_by_zero, overflow} !== 4'b1000) begin
            errors++; $display("FAIL midrun_reset_ctrl: got %b expected 1000", {in_ready, out_valid, div_by_zero, overflow});
        end
        checks++; if ({quotient, remainder} !== 32'h0) begin errors++; $display("FAIL midrun_reset_results: got %h/%h expected 0/0", quotient, remainder); end
        @(negedge clk);
        rst_n = 1'b1;
        do_div(32'h00000064, 16'h000A, rdy, lat, q, r, z, o);
        checks++; if (rdy !== 1'b1 || lat != 17) begin errors++; $display("FAIL midrun_new_timing: got ready %b latency %0d expected 1/17", rdy, lat); end
        checks++; if ({q, r, z, o} !== {16'h000A, 16'h0000, 2'b00}) begin
            errors++; $display("FAIL midrun_new_result: got %h/%h flags %b expected 000a/0000 flags 00", q, r, {z, o});
        end
        retire();
    endtask

    task automatic test_random();
        logic [31:0] dd;
        logic [15:0] dv, eq, er, q, r;
        logic ez, eo, z, o, rdy;
        int elat, lat, kind;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 7);
            dv = 16'($urandom_range(1, 65535));
            if (kind == 0) begin
                dd = $urandom; dv = 16'h0;
            end else if (kind == 1) begin
                dd = {16'($urandom_range(dv, 65535)), 16'($urandom)};
            end else begin
                dd = {16'($urandom_range(0, dv - 1)), 16'($urandom)};
            end
            model(dd, dv, eq, er, ez, eo, elat);
            do_div(dd, dv, rdy, lat, q, r, z, o);
            checks++; if (rdy !== 1'b1 || lat != elat) begin errors++; $display("FAIL rand%0d_timing: got ready %b latency %0d expected 1/%0d", i, rdy, lat, elat); end
            checks++; if ({q, r, z, o} !== {eq, er, ez, eo}) begin
                errors++; $display("FAIL rand%0d_result: %h/%h got %h/%h flags %b expected %h/%h flags %b", i, dd, dv, q, r, {z, o}, eq, er, {ez, eo});
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            retire();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dd;
        logic [15:0] dv, eq, er, q, r;
        logic ez, eo, z, o, rdy;
        int elat, lat;
        for (int i = 0; i < 6; i++) begin
            dv = 16'($urandom_range(1, 65535));
            dd = {16'($urandom_range(0, dv - 1)), 16'($urandom)};
            model(dd, dv, eq, er, ez, eo, elat);
            do_div(dd, dv, rdy, lat, q, r, z, o);
            checks++; if (rdy !== 1'b1 || lat != elat) begin errors++; $display("FAIL b2b%0d_timing: got ready %b latency %0d expected 1/%0d", i, rdy, lat, elat); end
            checks++; if ({q, r} !== {eq, er}) begin errors++; $display("FAIL b2b%0d_result: got %h/%h expected %h/%h", i, q, r, eq, er); end
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
